muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers for the single-issue MIPS datapath.
- Consumes the two operands read from the general-purpose register file: rs_data on port A and rt_data on port B.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds results in HI/LO. The MFHI/MFLO path returns them to the register-file write-data mux.
- The control unit stalls issue while busy is high.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_if.sv | 37 +++
 rtl/muldiv_step.sv | 43 ++++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   op_e      - operation encodings as presented on the op port
//   state_e   - control FSM states
//   ITER_LAST - final iteration index; one iteration runs per CALC cycle
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  localparam int ITER_LAST = 31;

endpackage : muldiv_pkg

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Issue/result bundle between the datapath control and the multiply/divide
// unit.
//   start, op       - launch request and operation select
//   rs_data/rt_data - operand A / operand B from the register file
//   mthi/mtlo       - direct writes of rs_data into HI/LO
//   busy, done      - operation in flight / one-cycle completion pulse
//   hi, lo          - architectural HI/LO registers
// master: the issuing side. slave: the muldiv_unit.
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo,
    output busy, done, hi, lo
  );

endinterface : muldiv_if

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the multiply/divide datapath.
//   acc_i    - 2*WIDTH accumulator {upper, lower}
//   opnd_i   - multiplicand (multiply) or divisor (divide), unsigned
//   is_div_i - 1: restoring divide step, 0: shift-add multiply step
//   acc_o    - accumulator after this iteration
// Multiply: lower half holds the not-yet-consumed multiplier bits; the
//   multiplicand is added into the upper half when the LSB is set, then the
//   whole accumulator shifts right, carry included.
// Divide: {remainder, dividend/quotient}. Shift left one, trial-subtract the
//   divisor from the remainder and shift the quotient bit in at the bottom.
// -----------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // NOTE: every output of a combinational block gets a value on every path
  // (here by computing all intermediates unconditionally), so no latch forms.
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_i};
    if (is_div_i) begin
      // remainder < divisor on entry, so a non-negative difference always
      // fits in WIDTH bits and bit WIDTH acts as the borrow flag.
      if (!diff[WIDTH]) acc_o = {diff[WIDTH-1:0],   acc_i[WIDTH-2:0], 1'b1};
      else              acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule : muldiv_step

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - muldiv_if slave: start/op/rs_data/rt_data/mthi/mtlo in,
//         busy/done/hi/lo out
// Signed operations run unsigned on absolute values; the result signs are
// recorded at start and applied in FIX. A divide by zero bypasses CALC and
// returns lo=all-ones, hi=dividend, uncorrected.
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = ITER_LAST + 1
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(ITER);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, step_acc;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;   // product / quotient sign
  logic                 neg_hi_q, neg_hi_d;   // remainder sign (divide only)
  logic                 done_q, done_d;

  op_e                  op;
  logic                 op_signed, op_div;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign op        = op_e'(bus.op);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign a_neg     = op_signed && bus.rs_data[WIDTH-1];
  assign b_neg     = op_signed && bus.rt_data[WIDTH-1];
  assign a_abs     = a_neg ? -bus.rs_data : bus.rs_data;
  assign b_abs     = b_neg ? -bus.rt_data : bus.rt_data;

  // Sign correction applied on the way into HI/LO.
  assign prod_fix  = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix   = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_div_d = op_div;
          cnt_d    = '0;
          if (op_div && (bus.rt_data == '0)) begin
            // Preload the final answer so FIX writes it with no correction.
            acc_d    = {bus.rs_data, {WIDTH{1'b1}}};
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
            state_d  = S_FIX;
          end else begin
            // Multiply: multiplier sits in the low half, multiplicand is added.
            // Divide: dividend sits in the low half, divisor is subtracted.
            acc_d    = {{WIDTH{1'b0}}, op_div ? a_abs : b_abs};
            opnd_d   = op_div ? b_abs : a_abs;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            state_d  = S_CALC;
          end
        end else begin
          if (bus.mthi) hi_d = bus.rs_data;
          if (bus.mtlo) lo_d = bus.rs_data;
        end
      end

      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule : muldiv_unit
